modn_updown_counter: RTL and testbench



---
 rtl/modn_updown_counter_pkg.sv | 23 ++
 rtl/modn_updown_counter_if.sv | 37 +++
 rtl/modn_updown_counter_bcd.sv | 15 +
 rtl/modn_updown_counter.sv | 99 +++++++++
 tb/tb_modn_updown_counter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/modn_updown_counter_pkg.sv
// rtl/modn_updown_counter_pkg.sv - shared constants, BCD digit type and clog2 for the clock counters
package clock_pkg;

  localparam int MAX_BCD_MOD = 100;
  localparam int SEC_MOD     = 60;
  localparam int MIN_MOD     = 60;
  localparam int HOUR_MOD    = 24;

  typedef logic [3:0] bcd_digit_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// rtl/modn_updown_counter_if.sv - control/status bundle of one counter stage; BCD_OUT_EN adds the BCD digits
interface modn_updown_counter_if
  import clock_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             carry_out;
  logic             load_err;
`ifdef BCD_OUT_EN
  bcd_digit_t       bcd_tens;
  bcd_digit_t       bcd_ones;
`endif

  modport master (
    output en, up, clr, load, load_val,
    input  count, carry_out, load_err
`ifdef BCD_OUT_EN
    , input bcd_tens, bcd_ones
`endif
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, carry_out, load_err
`ifdef BCD_OUT_EN
    , output bcd_tens, bcd_ones
`endif
  );

endinterface

// File: rtl/modn_updown_counter_bcd.sv
// rtl/modn_updown_counter_bcd.sv - combinational 0..99 binary to two BCD digits
module bin2bcd_2digit
  import clock_pkg::*;
(
  input  logic [6:0] bin,
  output bcd_digit_t tens,
  output bcd_digit_t ones
);

  always_comb begin
    tens = 4'(bin / 7'd10);
    ones = 4'(bin % 7'd10);
  end

endmodule

// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - modulo-MOD up/down counter with same-cycle carry for chaining
// Optional BCD display outputs when BCD_OUT_EN is defined.
module modn_updown_counter
  import clock_pkg::*;
#(
  parameter int MOD   = 60,
  parameter int WIDTH = 8,
  parameter int INIT  = 0
)(
  input  logic                 clk,
  input  logic                 reset,
  modn_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);

  if (MOD < 2) begin : g_bad_mod
    $error("modn_updown_counter: MOD must be >= 2");
  end
  if (clog2(MOD) > WIDTH) begin : g_bad_width
    $error("modn_updown_counter: WIDTH too small for MOD");
  end
  if (INIT < 0 || INIT >= MOD) begin : g_bad_init
    $error("modn_updown_counter: INIT out of range");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic             load_err_q;
  logic             load_err_nxt;
  logic             load_in_range;

  // Extra bit so a load_val equal to 2**WIDTH-1 compares correctly when MOD == 2**WIDTH.
  assign load_in_range = ({1'b0, bus.load_val} < MOD_W);

  always_comb begin
    count_nxt    = count_q;
    load_err_nxt = 1'b0;
    if (bus.clr) begin
      count_nxt = '0;
    end else if (bus.load) begin
      if (load_in_range) begin
        count_nxt = bus.load_val;
      end else begin
        count_nxt    = TOP;
        load_err_nxt = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up) count_nxt = (count_q == TOP) ? '0 : count_q + WIDTH'(1);
      else        count_nxt = (count_q == '0) ? TOP : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= WIDTH'(INIT);
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_nxt;
      load_err_q <= load_err_nxt;
    end
  end

  assign bus.count     = count_q;
  assign bus.load_err  = load_err_q;
  assign bus.carry_out = bus.en & (bus.up ? (count_q == TOP) : (count_q == '0))
                         & ~bus.clr & ~bus.load;

`ifdef BCD_OUT_EN
  if (MOD > MAX_BCD_MOD) begin : g_bad_bcd_mod
    $error("modn_updown_counter: BCD output requires MOD <= 100");
  end

  bcd_digit_t tens_nxt, ones_nxt;
  bcd_digit_t tens_q, ones_q;

  // Converting the next value keeps the digit registers on the same edge as count.
  bin2bcd_2digit u_bcd (
    .bin  (7'(count_nxt)),
    .tens (tens_nxt),
    .ones (ones_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q <= 4'(INIT / 10);
      ones_q <= 4'(INIT % 10);
    end else begin
      tens_q <= tens_nxt;
      ones_q <= ones_nxt;
    end
  end

  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// tb/tb_modn_updown_counter.sv - self-checking bench: directed scenarios plus randomized model comparison
module tb_modn_updown_counter;

  localparam int MOD_S = 60;
  localparam int MOD_H = 24;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  modn_updown_counter_if #(.WIDTH(8)) s_if ();
  modn_updown_counter_if #(.WIDTH(5)) h_if ();

  assign h_if.en = s_if.carry_out;

  modn_updown_counter #(.MOD(MOD_S), .WIDTH(8), .INIT(0)) u_sec (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if)
  );

  modn_updown_counter #(.MOD(MOD_H), .WIDTH(5), .INIT(0)) u_hour (
    .clk   (clk),
    .reset (reset),
    .bus   (h_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_if.en = 0; s_if.up = 1; s_if.clr = 0; s_if.load = 0; s_if.load_val = '0;
    h_if.up = 1; h_if.clr = 0; h_if.load = 0; h_if.load_val = '0;
  endtask

  task automatic load_sec(input int v);
    s_if.load = 1; s_if.load_val = 8'(v);
    tick();
    s_if.load = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #12;
    checks++;
    if (s_if.count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", s_if.count); end
    checks++;
    if (s_if.load_err !== 1'b0) begin fails++; $display("FAIL reset_load_err: got %b want 0", s_if.load_err); end
    checks++;
    if (s_if.carry_out !== 1'b0) begin fails++; $display("FAIL reset_carry: got %b want 0", s_if.carry_out); end
    @(negedge clk);
    reset = 0;
    tick();
  endtask

  task automatic test_count_up();
    s_if.en = 1; s_if.up = 1;
    for (int i = 0; i <= MOD_S; i++) begin
      checks++;
      if (s_if.count !== 8'(i % MOD_S)) begin
        fails++; $display("FAIL up_count[%0d]: got %0d want %0d", i, s_if.count, i % MOD_S);
      end
      checks++;
      if (s_if.carry_out !== ((i % MOD_S) == MOD_S - 1)) begin
        fails++; $display("FAIL up_carry[%0d]: got %b want %b", i, s_if.carry_out, (i % MOD_S) == MOD_S - 1);
      end
      tick();
    end
    s_if.en = 0;
  endtask

  task automatic test_count_down();
    load_sec(0);
    s_if.en = 1; s_if.up = 0;
    #1;
    checks++;
    if (s_if.carry_out !== 1'b1) begin fails++; $display("FAIL down_carry_at_0: got %b want 1", s_if.carry_out); end
    for (int k = 59; k >= 57; k--) begin
      tick();
      checks++;
      if (s_if.count !== 8'(k)) begin fails++; $display("FAIL down_count: got %0d want %0d", s_if.count, k); end
      checks++;
      if (s_if.carry_out !== 1'b0) begin fails++; $display("FAIL down_carry: got %b want 0", s_if.carry_out); end
    end
    s_if.en = 0; s_if.up = 1;
  endtask

  task automatic test_load();
    load_sec(75);
    checks++;
    if (s_if.count !== 8'd59) begin fails++; $display("FAIL load_oor_count: got %0d want 59", s_if.count); end
    checks++;
    if (s_if.load_err !== 1'b1) begin fails++; $display("FAIL load_oor_err: got %b want 1", s_if.load_err); end
    tick();
    checks++;
    if (s_if.load_err !== 1'b0) begin fails++; $display("FAIL load_err_pulse: got %b want 0", s_if.load_err); end
    load_sec(30);
    checks++;
    if (s_if.count !== 8'd30) begin fails++; $display("FAIL load_ok_count: got %0d want 30", s_if.count); end
    checks++;
    if (s_if.load_err !== 1'b0) begin fails++; $display("FAIL load_ok_err: got %b want 0", s_if.load_err); end
  endtask

  task automatic test_clr_load_priority();
    load_sec(59);
    s_if.en = 1; s_if.up = 1; s_if.clr = 1;
    #1;
    checks++;
    if (s_if.carry_out !== 1'b0) begin fails++; $display("FAIL clr_carry: got %b want 0", s_if.carry_out); end
    tick();
    s_if.clr = 0; s_if.en = 0;
    checks++;
    if (s_if.count !== 8'd0) begin fails++; $display("FAIL clr_count: got %0d want 0", s_if.count); end
    load_sec(59);
    s_if.en = 1; s_if.load = 1; s_if.load_val = 8'd10;
    #1;
    checks++;
    if (s_if.carry_out !== 1'b0) begin fails++; $display("FAIL load_carry: got %b want 0", s_if.carry_out); end
    tick();
    s_if.load = 0; s_if.en = 0;
    checks++;
    if (s_if.count !== 8'd10) begin fails++; $display("FAIL load_over_en: got %0d want 10", s_if.count); end
  endtask

  task automatic test_chain();
    s_if.load = 1; s_if.load_val = 8'd59;
    h_if.load = 1; h_if.load_val = 5'd23;
    tick();
    s_if.load = 0; h_if.load = 0;
    s_if.en = 1; s_if.up = 1; h_if.up = 1;
    #1;
    checks++;
    if (h_if.carry_out !== 1'b1) begin fails++; $display("FAIL chain_hour_carry: got %b want 1", h_if.carry_out); end
    tick();
    checks++;
    if (s_if.count !== 8'd0 || h_if.count !== 5'd0) begin
      fails++; $display("FAIL chain_wrap: got sec=%0d hour=%0d want 0/0", s_if.count, h_if.count);
    end
    tick();
    checks++;
    if (s_if.count !== 8'd1 || h_if.count !== 5'd0) begin
      fails++; $display("FAIL chain_after: got sec=%0d hour=%0d want 1/0", s_if.count, h_if.count);
    end
    s_if.en = 0;
  endtask

  task automatic test_reset_mid();
`ifdef BCD_OUT_EN
    load_sec(47);
    checks++;
    if (s_if.bcd_tens !== 4'd4 || s_if.bcd_ones !== 4'd7) begin
      fails++; $display("FAIL bcd_47: got %0d%0d want 47", s_if.bcd_tens, s_if.bcd_ones);
    end
`endif
    load_sec(37);
    s_if.en = 1;
    #2;
    reset = 1;
    #1;
    checks++;
    if (s_if.count !== 8'd0) begin fails++; $display("FAIL reset_mid: got %0d want 0", s_if.count); end
`ifdef BCD_OUT_EN
    checks++;
    if (s_if.bcd_tens !== 4'd0 || s_if.bcd_ones !== 4'd0) begin
      fails++; $display("FAIL bcd_reset: got %0d%0d want 00", s_if.bcd_tens, s_if.bcd_ones);
    end
`endif
    s_if.en = 0;
    @(negedge clk);
    reset = 0;
    tick();
  endtask

  task automatic test_random();
    int exp_cnt, exp_err, nxt, lv;
    bit en, up, clr, ld, exp_carry;
    exp_cnt = 0;
    exp_err = 0;
    for (int i = 0; i < 500; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      up  = $urandom_range(0, 1);
      clr = ($urandom_range(0, 15) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      lv  = $urandom_range(0, 99);
      s_if.en = en; s_if.up = up; s_if.clr = clr; s_if.load = ld; s_if.load_val = 8'(lv);
      #1;
      exp_carry = en && !clr && !ld && (up ? (exp_cnt + 1 == MOD_S) : (exp_cnt == 0));
      checks++;
      if (s_if.carry_out !== exp_carry) begin
        fails++; $display("FAIL rand_carry[%0d]: got %b want %b", i, s_if.carry_out, exp_carry);
      end
      if (clr)      begin nxt = 0; exp_err = 0; end
      else if (ld)  begin nxt = (lv < MOD_S) ? lv : MOD_S - 1; exp_err = (lv >= MOD_S); end
      else if (en)  begin nxt = (exp_cnt + (up ? 1 : MOD_S - 1)) % MOD_S; exp_err = 0; end
      else          begin nxt = exp_cnt; exp_err = 0; end
      exp_cnt = nxt;
      tick();
      checks++;
      if (s_if.count !== 8'(exp_cnt)) begin
        fails++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, s_if.count, exp_cnt);
      end
      checks++;
      if (s_if.load_err !== 1'(exp_err)) begin
        fails++; $display("FAIL rand_load_err[%0d]: got %b want %0d", i, s_if.load_err, exp_err);
      end
`ifdef BCD_OUT_EN
      checks++;
      if (s_if.bcd_tens !== 4'(exp_cnt / 10) || s_if.bcd_ones !== 4'(exp_cnt % 10)) begin
        fails++; $display("FAIL rand_bcd[%0d]: got %0d%0d want %0d", i, s_if.bcd_tens, s_if.bcd_ones, exp_cnt);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_clr_load_priority();
    test_chain();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
